fpnew_divsqrt_issue_queue: RTL and testbench
============================================

# fpnew_divsqrt_issue_queue

Small in-order request queue placed directly upstream of the multi-cycle divide/square-root unit within the FPU's DIVSQRT operation group. It accepts div/sqrt requests from the opgroup dispatcher and presents them one at a time to the iterative unit, so upstream is not back-pressured while the unit is busy. It supports a synchronous flush that drops all queued requests and reports occupancy for busy tracking.

## Interface
- WIDTH, 64: operand width in bits.
- DEPTH, 4: number of queue entries; legal range 2..16, need not be a power of two.
- TagType, logic: request tag type, carried unchanged.
- AuxType, logic: auxiliary sideband type, carried unchanged.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- operands_i  in  2×WIDTH  operand 0 (dividend/radicand) and operand 1 (divisor).
- rnd_mode_i  in  fpnew_pkg::roundmode_e  rounding mode.
- op_i  in  fpnew_pkg::operation_e  DIV or SQRT; other values are queued unchanged.
- dst_fmt_i  in  fpnew_pkg::fp_format_e  destination format.
- tag_i / aux_i  in  TagType / AuxType  sideband.
- in_valid_i  in  1  request valid.
- in_ready_o  out  1  queue can accept a request.
- flush_i  in  1  synchronous flush.
- operands_o, rnd_mode_o, op_o, dst_fmt_o, tag_o, aux_o  out  same widths as inputs  head-of-queue request.
- out_valid_o  out  1  head request valid.
- out_ready_i  in  1  downstream unit accepts head.
- usage_o  out  $clog2(DEPTH+1)  current entry count.
- busy_o  out  1  at least one entry held.

## Operation
- Storage: DEPTH-entry circular buffer; write pointer, read pointer, count. Pointers wrap from DEPTH-1 to 0.
- Push when in_valid_i & in_ready_o: entry written at write pointer, write pointer advances.
- Pop when out_valid_o & out_ready_i: read pointer advances.
- in_ready_o = (count < DEPTH) & ~flush_i. Pop does not free space in the same cycle: no push when full, even with a simultaneous pop.
- out_valid_o = (count != 0) & ~flush_i (bypass case below).
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
- Order strictly FIFO; payload fields are never modified.
- usage_o = count; busy_o = (count != 0).
- Flush: takes priority over push and pop. In the flush cycle in_ready_o = 0 and out_valid_o = 0. Next edge: count, both pointers = 0. Entry contents are not cleared.
- Reset (async): count = 0, pointers = 0. Outputs after reset: in_ready_o = 1, out_valid_o = 0, usage_o = 0, busy_o = 0. Payload outputs are 0.
- Payload outputs show the head entry whenever out_valid_o = 1. Otherwise their value is don't-care but stable.

## Timing
- Without bypass: request accepted at edge N is presented with out_valid_o = 1 in cycle N+1.
- Throughput: one push and one pop per cycle.
- Full-to-ready: pop at edge N; in_ready_o = 1 in cycle N+1.
- No combinational path from out_ready_i to in_ready_o. With bypass, the only combinational path from in_valid_i to out_valid_o is the empty-queue pass-through.

## Configuration
- FPNEW_DIVSQRT_QUEUE_BYPASS_EN defined:
  - When count == 0 and in_valid_i = 1, the input request drives the outputs combinationally: out_valid_o = 1, payload equals the inputs.
  - If out_ready_i = 1 in that cycle, the request is consumed without being written; count and pointers are unchanged.
  - If out_ready_i = 0, the request is written normally.
  - Zero-cycle latency when empty.
- Undefined: no pass-through; minimum latency one cycle as above.
- Flush suppresses the bypass path in both configurations.

## Test plan
- Reset, then push 4 DIV requests with tags 1..4 while out_ready_i = 0:
  - usage_o reaches 4, in_ready_o = 0.
  - 5th request (tag 5) is held off.
  - Raise out_ready_i: tags emerge 1,2,3,4 on consecutive cycles, then tag 5 follows.
- Steady stream at count = 2 with in_valid_i = out_ready_i = 1 for 10 cycles: usage_o stays 2, tags emerge in order, pointers wrap without loss.
- With DEPTH = 3, push/pop pattern forcing more than 3 wraps: no duplication or loss (scoreboard compare of 50 random requests under random out_ready_i).
- Flush with 3 entries queued plus in_valid_i = 1 in the same cycle:
  - In that cycle in_ready_o = 0 and out_valid_o = 0.
  - Next cycle usage_o = 0, busy_o = 0.
  - A new request (tag 9) pushed afterwards is the next one output.
- Empty queue, single request tag 7 with out_ready_i = 1:
  - Bypass build: out_valid_o = 1 and tag_o = 7 in the same cycle, usage_o stays 0.
  - Non-bypass build: out_valid_o = 1 one cycle later.
- Assert rst_ni low mid-stream with 2 entries: out_valid_o = 0, usage_o = 0, in_ready_o = 1 immediately (asynchronously), before the next clock edge.

Source files
------------

// File: rtl/fpnew_divsqrt_issue_queue.sv
// -----------------------------------------------------------------------------
// fpnew_divsqrt_issue_queue
//
// In-order request queue that sits in front of the iterative divide/sqrt unit.
// The opgroup dispatcher can keep pushing div/sqrt requests while the unit is
// busy. The unit then takes them one at a time from the head of the queue.
//
// Configuration macro:
//   FPNEW_DIVSQRT_QUEUE_BYPASS_EN - when defined, a request that arrives while
//   the queue is empty drives the outputs combinationally in the same cycle.
//   If the unit accepts it in that cycle, it is never written to storage.
//   When the macro is undefined, the minimum latency is one cycle.
//
// Parameters:
//   WIDTH   operand width in bits
//   DEPTH   number of entries (2..16, any value in that range)
//   TagType request tag type, carried unchanged
//   AuxType sideband type, carried unchanged
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   operands_i ...aux_i  incoming request payload
//   in_valid_i/in_ready_o    upstream handshake
//   flush_i              synchronous flush; drops every queued request
//   operands_o ...aux_o  head-of-queue payload
//   out_valid_o/out_ready_i  downstream handshake
//   usage_o              number of entries currently held
//   busy_o               at least one entry held
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. A source holds valid and payload until that transfer. The ready
// outputs depend only on state and flush_i. in_ready_o never depends on
// out_ready_i, so a pop does not make room for a push in the same cycle.
// -----------------------------------------------------------------------------

package fpnew_pkg;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100,
        ROD = 3'b101,
        DYN = 3'b111
    } roundmode_e;

    typedef enum logic [3:0] {
        FMADD, FNMSUB, ADD, MUL,
        DIV, SQRT,
        SGNJ, MINMAX, CMP, CLASSIFY,
        F2F, F2I, I2F, CPKAB, CPKCD
    } operation_e;

    typedef enum logic [2:0] {
        FP32    = 3'd0,
        FP64    = 3'd1,
        FP16    = 3'd2,
        FP8     = 3'd3,
        FP16ALT = 3'd4
    } fp_format_e;

endpackage

module fpnew_divsqrt_issue_queue #(
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned DEPTH   = 4,
    parameter type         TagType = logic,
    parameter type         AuxType = logic
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    // Upstream request
    input  logic [1:0][WIDTH-1:0]         operands_i,
    input  fpnew_pkg::roundmode_e         rnd_mode_i,
    input  fpnew_pkg::operation_e         op_i,
    input  fpnew_pkg::fp_format_e         dst_fmt_i,
    input  TagType                        tag_i,
    input  AuxType                        aux_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    // Flush
    input  logic                          flush_i,
    // Downstream request (head of queue)
    output logic [1:0][WIDTH-1:0]         operands_o,
    output fpnew_pkg::roundmode_e         rnd_mode_o,
    output fpnew_pkg::operation_e         op_o,
    output fpnew_pkg::fp_format_e         dst_fmt_o,
    output TagType                        tag_o,
    output AuxType                        aux_o,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    // Status
    output logic [$clog2(DEPTH+1)-1:0]    usage_o,
    output logic                          busy_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam ptr_t LAST_PTR = ptr_t'(DEPTH - 1);
    localparam cnt_t FULL_CNT = cnt_t'(DEPTH);

    typedef struct packed {
        logic [1:0][WIDTH-1:0] operands;
        fpnew_pkg::roundmode_e rnd_mode;
        fpnew_pkg::operation_e op;
        fpnew_pkg::fp_format_e dst_fmt;
        TagType                tag;
        AuxType                aux;
    } entry_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    entry_t mem_q [DEPTH];
    entry_t mem_d [DEPTH];
    ptr_t   wr_ptr_q, wr_ptr_d;
    ptr_t   rd_ptr_q, rd_ptr_d;
    cnt_t   cnt_q,    cnt_d;

    entry_t in_entry;
    entry_t out_entry;
    logic   not_empty;
    logic   bypass_act;   // empty queue, incoming request shown on outputs
    logic   push_mem;     // request written into storage this cycle
    logic   pop_mem;      // head entry leaves storage this cycle

    // Pointers step by one. They wrap explicitly because DEPTH does not have
    // to be a power of two.
    function automatic ptr_t next_ptr(input ptr_t p);
        return (p == LAST_PTR) ? '0 : p + ptr_t'(1);
    endfunction

    assign in_entry = '{
        operands: operands_i,
        rnd_mode: rnd_mode_i,
        op:       op_i,
        dst_fmt:  dst_fmt_i,
        tag:      tag_i,
        aux:      aux_i
    };

    assign not_empty = (cnt_q != '0);

    // -------------------------------------------------------------------------
    // Handshake outputs
    // -------------------------------------------------------------------------
    always_comb begin
        bypass_act = 1'b0;
`ifdef FPNEW_DIVSQRT_QUEUE_BYPASS_EN
        // Pass-through is the only in_valid_i -> out_valid_o path. It is
        // suppressed by flush.
        bypass_act = ~not_empty & in_valid_i & ~flush_i;
`endif
    end

    assign in_ready_o  = (cnt_q < FULL_CNT) & ~flush_i;
    assign out_valid_o = (not_empty | bypass_act) & ~flush_i;

    // A bypassed request that is taken in the same cycle is never stored.
    assign push_mem = in_valid_i & in_ready_o & ~(bypass_act & out_ready_i);
    assign pop_mem  = out_valid_o & out_ready_i & not_empty;

    // -------------------------------------------------------------------------
    // Next state
    // -------------------------------------------------------------------------
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;

        if (flush_i) begin
            // Entry contents are left as they are. Only the bookkeeping is
            // reset.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push_mem) begin
                mem_d[wr_ptr_q] = in_entry;
                wr_ptr_d        = next_ptr(wr_ptr_q);
            end
            if (pop_mem) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end
            unique case ({push_mem, pop_mem})
                2'b10:   cnt_d = cnt_q + cnt_t'(1);
                2'b01:   cnt_d = cnt_q - cnt_t'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // Storage is reset so that the payload outputs read zero after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // When nothing is valid, the outputs show the entry at the read pointer.
    // That entry is stable until the next write or flush.
    assign out_entry = bypass_act ? in_entry : mem_q[rd_ptr_q];

    assign operands_o = out_entry.operands;
    assign rnd_mode_o = out_entry.rnd_mode;
    assign op_o       = out_entry.op;
    assign dst_fmt_o  = out_entry.dst_fmt;
    assign tag_o      = out_entry.tag;
    assign aux_o      = out_entry.aux;

    assign usage_o = cnt_q;
    assign busy_o  = not_empty;

endmodule

// File: tb/tb_fpnew_divsqrt_issue_queue.sv
// Testbench for fpnew_divsqrt_issue_queue.
// A DEPTH=4 instance runs the directed scenarios.
// A DEPTH=3 instance runs the randomized wrap-around scenario.
// Expected payloads go into queues when the DUT accepts a request.
// They are popped and compared when the DUT hands a request downstream.

module tb_fpnew_divsqrt_issue_queue;

  localparam int W     = 64;
  localparam int EXP_W = 2 * W + 4 + 3 + 3 + 4 + 8;

  typedef logic [7:0] tag_t;
  typedef logic [3:0] aux_t;

  // clock / reset
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=4 instance signals
  logic [1:0][W-1:0]     operands_i;
  fpnew_pkg::roundmode_e rnd_mode_i;
  fpnew_pkg::operation_e op_i;
  fpnew_pkg::fp_format_e dst_fmt_i;
  tag_t                  tag_i;
  aux_t                  aux_i;
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic                  flush_i;
  logic [1:0][W-1:0]     operands_o;
  fpnew_pkg::roundmode_e rnd_mode_o;
  fpnew_pkg::operation_e op_o;
  fpnew_pkg::fp_format_e dst_fmt_o;
  tag_t                  tag_o;
  aux_t                  aux_o;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [2:0]            usage_o;
  logic                  busy_o;

  // DEPTH=3 instance signals
  logic [1:0][W-1:0]     operands3_i;
  tag_t                  tag3_i;
  aux_t                  aux3_i;
  logic                  in_valid3_i;
  logic                  in_ready3_o;
  logic [1:0][W-1:0]     operands3_o;
  fpnew_pkg::roundmode_e rnd_mode3_o;
  fpnew_pkg::operation_e op3_o;
  fpnew_pkg::fp_format_e dst_fmt3_o;
  tag_t                  tag3_o;
  aux_t                  aux3_o;
  logic                  out_valid3_o;
  logic                  out_ready3_i;
  logic [1:0]            usage3_o;
  logic                  busy3_o;

  logic [EXP_W-1:0] cur_in, cur_out, cur_in3, cur_out3;
  assign cur_in   = {operands_i, op_i, rnd_mode_i, dst_fmt_i, aux_i, tag_i};
  assign cur_out  = {operands_o, op_o, rnd_mode_o, dst_fmt_o, aux_o, tag_o};
  assign cur_in3  = {operands3_i, op_i, rnd_mode_i, dst_fmt_i, aux3_i, tag3_i};
  assign cur_out3 = {operands3_o, op3_o, rnd_mode3_o, dst_fmt3_o, aux3_o, tag3_o};

  // scoreboard
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] exp3_q[$];
  int n_checks = 0;
  int n_errors = 0;

  fpnew_divsqrt_issue_queue #(
    .WIDTH(W), .DEPTH(4), .TagType(tag_t), .AuxType(aux_t)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .operands_i(operands_i), .rnd_mode_i(rnd_mode_i), .op_i(op_i),
    .dst_fmt_i(dst_fmt_i), .tag_i(tag_i), .aux_i(aux_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .flush_i(flush_i),
    .operands_o(operands_o), .rnd_mode_o(rnd_mode_o), .op_o(op_o),
    .dst_fmt_o(dst_fmt_o), .tag_o(tag_o), .aux_o(aux_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .usage_o(usage_o), .busy_o(busy_o)
  );

  fpnew_divsqrt_issue_queue #(
    .WIDTH(W), .DEPTH(3), .TagType(tag_t), .AuxType(aux_t)
  ) dut3 (
    .clk_i(clk), .rst_ni(rst_n),
    .operands_i(operands3_i), .rnd_mode_i(rnd_mode_i), .op_i(op_i),
    .dst_fmt_i(dst_fmt_i), .tag_i(tag3_i), .aux_i(aux3_i),
    .in_valid_i(in_valid3_i), .in_ready_o(in_ready3_o), .flush_i(1'b0),
    .operands_o(operands3_o), .rnd_mode_o(rnd_mode3_o), .op_o(op3_o),
    .dst_fmt_o(dst_fmt3_o), .tag_o(tag3_o), .aux_o(aux3_o),
    .out_valid_o(out_valid3_o), .out_ready_i(out_ready3_i),
    .usage_o(usage3_o), .busy_o(busy3_o)
  );

  // driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input tag_t t);
    in_valid_i    = v;
    tag_i         = t;
    aux_i         = t[3:0];
    operands_i[0] = {$urandom, $urandom};
    operands_i[1] = {$urandom, $urandom};
    op_i          = fpnew_pkg::DIV;
    rnd_mode_i    = fpnew_pkg::roundmode_e'({1'b0, t[1:0]});
    dst_fmt_i     = fpnew_pkg::FP64;
  endtask

  task automatic set_req3(input logic v, input tag_t t);
    in_valid3_i    = v;
    tag3_i         = t;
    aux3_i         = t[3:0];
    operands3_i[0] = {$urandom, $urandom};
    operands3_i[1] = {$urandom, $urandom};
  endtask

  // tests
  task automatic test_reset();
    rst_n        = 1'b0;
    flush_i      = 1'b0;
    out_ready_i  = 1'b0;
    out_ready3_i = 1'b0;
    set_req(1'b0, 8'd0);
    set_req3(1'b0, 8'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready_o !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready_o); end
    n_checks++; if (out_valid_o !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid_o); end
    n_checks++; if (usage_o !== 3'd0) begin n_errors++; $display("FAIL reset_usage got=%0d exp=0", usage_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    n_checks++; if (cur_out !== '0) begin n_errors++; $display("FAIL reset_payload got=%h exp=0", cur_out); end
    next_cycle();
  endtask

  task automatic test_fill_and_drain();
    int got;
    logic sent5;
    logic [EXP_W-1:0] exp;
    out_ready_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      set_req(1'b1, tag_t'(i));
      @(negedge clk);
      n_checks++; if (in_ready_o !== 1'b1) begin n_errors++; $display("FAIL fill_ready[%0d] got=%b exp=1", i, in_ready_o); end
      if (in_valid_i && in_ready_o) exp_q.push_back(cur_in);
      next_cycle();
    end
    set_req(1'b1, 8'd5);
    @(negedge clk);
    n_checks++; if (usage_o !== 3'd4) begin n_errors++; $display("FAIL full_usage got=%0d exp=4", usage_o); end
    n_checks++; if (in_ready_o !== 1'b0) begin n_errors++; $display("FAIL full_in_ready got=%b exp=0", in_ready_o); end
    n_checks++; if (tag_o !== 8'd1) begin n_errors++; $display("FAIL full_head_tag got=%0d exp=1", tag_o); end
    next_cycle();
    @(negedge clk);
    n_checks++; if (in_ready_o !== 1'b0 || usage_o !== 3'd4) begin n_errors++; $display("FAIL held_off ready=%b usage=%0d exp ready=0 usage=4", in_ready_o, usage_o); end
    next_cycle();
    out_ready_i = 1'b1;
    got   = 0;
    sent5 = 1'b0;
    for (int c = 0; c < 12 && got < 5; c++) begin
      @(negedge clk);
      if (c == 0) begin
        n_checks++; if (in_ready_o !== 1'b0) begin n_errors++; $display("FAIL pop_no_room got=%b exp=0", in_ready_o); end
      end
      if (c == 1) begin
        n_checks++; if (in_ready_o !== 1'b1) begin n_errors++; $display("FAIL full_to_ready got=%b exp=1", in_ready_o); end
      end
      if (in_valid_i && in_ready_o) begin exp_q.push_back(cur_in); sent5 = 1'b1; end
      if (out_valid_o && out_ready_i) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_errors++; $display("FAIL drain_extra got tag=%0d exp=none", tag_o); end
        else begin
          exp = exp_q.pop_front();
          if (cur_out !== exp) begin n_errors++; $display("FAIL drain_data got=%h exp=%h", cur_out, exp); end
        end
        got++;
      end else begin
        n_checks++; n_errors++; $display("FAIL drain_gap cycle=%0d got out_valid=%b exp=1", c, out_valid_o);
      end
      next_cycle();
      if (sent5) in_valid_i = 1'b0;
    end
    n_checks++; if (got != 5) begin n_errors++; $display("FAIL drain_count got=%0d exp=5", got); end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [EXP_W-1:0] exp;
    out_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_req(1'b1, tag_t'(8'h20 + i));
      @(negedge clk);
      if (in_valid_i && in_ready_o) exp_q.push_back(cur_in);
      next_cycle();
    end
    set_req(1'b1, 8'h22);
    out_ready_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_checks++; if (usage_o !== 3'd2) begin n_errors++; $display("FAIL stream_usage[%0d] got=%0d exp=2", c, usage_o); end
      if (in_valid_i && in_ready_o) exp_q.push_back(cur_in);
      n_checks++;
      if (out_valid_o && out_ready_i && exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        if (cur_out !== exp) begin n_errors++; $display("FAIL stream_data[%0d] got=%h exp=%h", c, cur_out, exp); end
      end else begin
        n_errors++; $display("FAIL stream_pop[%0d] got out_valid=%b exp=1", c, out_valid_o);
      end
      next_cycle();
      if (c < 9) set_req(1'b1, tag_t'(8'h23 + c));
    end
    in_valid_i = 1'b0;
    for (int c = 0; c < 8 && exp_q.size() != 0; c++) begin
      @(negedge clk);
      if (out_valid_o && out_ready_i) begin
        exp = exp_q.pop_front();
        n_checks++; if (cur_out !== exp) begin n_errors++; $display("FAIL stream_drain got=%h exp=%h", cur_out, exp); end
      end
      next_cycle();
    end
    @(negedge clk);
    n_checks++; if (exp_q.size() != 0 || usage_o !== 3'd0) begin n_errors++; $display("FAIL stream_empty got left=%0d usage=%0d exp 0/0", exp_q.size(), usage_o); end
    next_cycle();
    out_ready_i = 1'b0;
  endtask

  task automatic test_flush();
    int got;
    logic [EXP_W-1:0] exp;
    out_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, tag_t'(8'h31 + i));
      @(negedge clk);
      if (in_valid_i && in_ready_o) exp_q.push_back(cur_in);
      next_cycle();
    end
    set_req(1'b1, 8'h38);
    flush_i     = 1'b1;
    out_ready_i = 1'b1;
    @(negedge clk);
    n_checks++; if (usage_o !== 3'd3) begin n_errors++; $display("FAIL flush_pre_usage got=%0d exp=3", usage_o); end
    n_checks++; if (in_ready_o !== 1'b0) begin n_errors++; $display("FAIL flush_in_ready got=%b exp=0", in_ready_o); end
    n_checks++; if (out_valid_o !== 1'b0) begin n_errors++; $display("FAIL flush_out_valid got=%b exp=0", out_valid_o); end
    exp_q.delete();
    next_cycle();
    flush_i    = 1'b0;
    in_valid_i = 1'b0;
    @(negedge clk);
    n_checks++; if (usage_o !== 3'd0) begin n_errors++; $display("FAIL flush_usage got=%0d exp=0", usage_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL flush_busy got=%b exp=0", busy_o); end
    next_cycle();
    set_req(1'b1, 8'd9);
    got = 0;
    for (int c = 0; c < 4 && got == 0; c++) begin
      @(negedge clk);
      if (in_valid_i && in_ready_o) exp_q.push_back(cur_in);
      if (out_valid_o && out_ready_i) begin
        n_checks++;
        if (exp_q.size() == 0) begin n_errors++; $display("FAIL post_flush_extra got tag=%0d exp=none", tag_o); end
        else begin
          exp = exp_q.pop_front();
          if (cur_out !== exp) begin n_errors++; $display("FAIL post_flush_data got tag=%0d exp tag=9", tag_o); end
        end
        got++;
      end
      next_cycle();
      in_valid_i = 1'b0;
    end
    n_checks++; if (got != 1) begin n_errors++; $display("FAIL post_flush_timeout got=%0d exp=1", got); end
    out_ready_i = 1'b0;
  endtask

  task automatic test_empty_latency();
    logic [EXP_W-1:0] exp;
    set_req(1'b1, 8'd7);
    out_ready_i = 1'b1;
    @(negedge clk);
    if (in_valid_i && in_ready_o) exp_q.push_back(cur_in);
`ifdef FPNEW_DIVSQRT_QUEUE_BYPASS_EN
    n_checks++; if (out_valid_o !== 1'b1) begin n_errors++; $display("FAIL bypass_valid got=%b exp=1", out_valid_o); end
    n_checks++; if (tag_o !== 8'd7) begin n_errors++; $display("FAIL bypass_tag got=%0d exp=7", tag_o); end
    n_checks++; if (usage_o !== 3'd0) begin n_errors++; $display("FAIL bypass_usage got=%0d exp=0", usage_o); end
    if (out_valid_o && exp_q.size() != 0) begin
      exp = exp_q.pop_front();
      n_checks++; if (cur_out !== exp) begin n_errors++; $display("FAIL bypass_data got=%h exp=%h", cur_out, exp); end
    end
    next_cycle();
    in_valid_i = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid_o !== 1'b0 || usage_o !== 3'd0) begin n_errors++; $display("FAIL bypass_after got valid=%b usage=%0d exp 0/0", out_valid_o, usage_o); end
`else
    n_checks++; if (out_valid_o !== 1'b0) begin n_errors++; $display("FAIL latency_early got=%b exp=0", out_valid_o); end
    next_cycle();
    in_valid_i = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid_o !== 1'b1) begin n_errors++; $display("FAIL latency_valid got=%b exp=1", out_valid_o); end
    n_checks++; if (tag_o !== 8'd7) begin n_errors++; $display("FAIL latency_tag got=%0d exp=7", tag_o); end
    n_checks++; if (usage_o !== 3'd1) begin n_errors++; $display("FAIL latency_usage got=%0d exp=1", usage_o); end
    if (out_valid_o && exp_q.size() != 0) begin
      exp = exp_q.pop_front();
      n_checks++; if (cur_out !== exp) begin n_errors++; $display("FAIL latency_data got=%h exp=%h", cur_out, exp); end
    end
    next_cycle();
    @(negedge clk);
    n_checks++; if (usage_o !== 3'd0) begin n_errors++; $display("FAIL latency_after_usage got=%0d exp=0", usage_o); end
`endif
    next_cycle();
    exp_q.delete();
    out_ready_i = 1'b0;
  endtask

  task automatic test_async_reset();
    out_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_req(1'b1, tag_t'(8'h41 + i));
      next_cycle();
    end
    in_valid_i = 1'b0;
    #2;
    n_checks++; if (usage_o !== 3'd2) begin n_errors++; $display("FAIL areset_pre_usage got=%0d exp=2", usage_o); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid_o !== 1'b0) begin n_errors++; $display("FAIL areset_out_valid got=%b exp=0", out_valid_o); end
    n_checks++; if (usage_o !== 3'd0) begin n_errors++; $display("FAIL areset_usage got=%0d exp=0", usage_o); end
    n_checks++; if (in_ready_o !== 1'b1) begin n_errors++; $display("FAIL areset_in_ready got=%b exp=1", in_ready_o); end
    n_checks++; if (cur_out !== '0) begin n_errors++; $display("FAIL areset_payload got=%h exp=0", cur_out); end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_random_wrap();
    int sent, got;
    logic [EXP_W-1:0] exp;
    sent = 0;
    got  = 0;
    set_req3(1'b1, 8'd0);
    out_ready3_i = 1'b0;
    for (int c = 0; c < 3000 && got < 50; c++) begin
      logic accepted;
      @(negedge clk);
      accepted = 1'b0;
      if (in_valid3_i && in_ready3_o) begin
        exp3_q.push_back(cur_in3);
        sent++;
        accepted = 1'b1;
      end
      if (out_valid3_o && out_ready3_i) begin
        n_checks++;
        if (exp3_q.size() == 0) begin n_errors++; $display("FAIL wrap_extra got tag=%0d exp=none", tag3_o); end
        else begin
          exp = exp3_q.pop_front();
          if (cur_out3 !== exp) begin n_errors++; $display("FAIL wrap_data got=%h exp=%h", cur_out3, exp); end
        end
        got++;
      end
      next_cycle();
      if (accepted || !in_valid3_i)
        set_req3((sent < 50) && ($urandom_range(0, 3) != 0), tag_t'(sent));
      out_ready3_i = ($urandom_range(0, 2) != 0);
    end
    in_valid3_i  = 1'b0;
    out_ready3_i = 1'b0;
    n_checks++; if (got != 50 || sent != 50) begin n_errors++; $display("FAIL wrap_count got sent=%0d recv=%0d exp 50/50", sent, got); end
    n_checks++; if (exp3_q.size() != 0) begin n_errors++; $display("FAIL wrap_left got=%0d exp=0", exp3_q.size()); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_fill_and_drain();
    test_back_to_back();
    test_flush();
    test_empty_latency();
    test_async_reset();
    test_random_wrap();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
